// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, round constants, S-box and key-schedule states.
package aes_pkg;
  localparam int NR    = 10;
  localparam int KEY_W = 128;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ks_state_t;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse computed as b^254 (so 0 maps to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gf_mul(inv, sq);
      sq = gf_mul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/key_round_step.sv
// rtl/key_round_step.sv - combinational AES-128 key expansion step, one round key to the next.
module key_round_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] words,
  input  logic [7:0]       rc,
  output logic [KEY_W-1:0] next_words
);
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = words;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign t  = sub ^ {rc, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_words = {n0, n1, n2, n3};
endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - iterative AES-128 key schedule emitting round keys 0..NR on a valid/ready handshake.
module key_schedule
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             key_valid,
  output logic             key_last,
  output logic             busy
);
  ks_state_t        state, state_next;
  logic [KEY_W-1:0] next_key;
  logic             handshake;
  logic             at_last;

  // In RUN there is always a valid key on the output, so valid and busy share the state flop.
  assign key_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign handshake = key_valid && key_ready;
  assign at_last   = (round_idx == 4'(NR));
  assign key_last  = key_valid && at_last;

  key_round_step u_step (
    .words      (round_key),
    .rc         (rcon(round_idx)),
    .next_words (next_key)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (handshake && at_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_key <= '0;
      round_idx <= '0;
    end else if (state == IDLE && start) begin
      round_key <= key_in;
      round_idx <= 4'd0;
    end else if (handshake && !at_last) begin
      round_key <= next_key;
      round_idx <= round_idx + 4'd1;
    end
  end
endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule against a FIPS-197 word-expansion model.
module tb_key_schedule;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [0:255];
  logic [127:0] ref_keys [0:10];

  key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_last  (key_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int gmul(int a, int b);
    int p = 0;
    while (b != 0) begin
      if ((b & 1) != 0) p ^= a;
      a = a << 1;
      if ((a & 'h100) != 0) a ^= 'h11b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from a brute-force inverse search and the bitwise affine formula.
  task automatic build_sbox();
    int inv, s, v;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      s = 'h63;
      for (int i = 0; i < 8; i++) begin
        v = (inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
            (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8));
        if ((v & 1) != 0) s ^= (1 << i);
      end
      sb[x] = 8'(s);
    end
  endtask

  task automatic compute_ref(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [127:0] key);
    start  = 1'b1;
    key_in = key;
    tick();
    start  = 1'b0;
    key_in = rand_key();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b1;
    tick(); tick();
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || round_key !== 128'h0 ||
        round_idx !== 4'd0 || key_last !== 1'b0) begin
      errors++;
      $display("FAIL reset valid=%b busy=%b idx=%0d last=%b key=%h want all zero",
               key_valid, busy, round_idx, key_last, round_key);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready valid=%b busy=%b want 0 0", key_valid, busy);
    end
  endtask

  task automatic test_plain_run(input logic [127:0] key, input logic [127:0] k1, input logic [127:0] k10);
    compute_ref(key);
    key_ready = 1'b1;
    launch(key);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== ref_keys[i] || key_last !== (i == 10)) begin
        errors++;
        $display("FAIL plain_seq i=%0d valid=%b idx=%0d last=%b key=%h want %h",
                 i, key_valid, round_idx, key_last, round_key, ref_keys[i]);
      end
      if (i == 1 || i == 10) begin
        checks++;
        if (round_key !== ((i == 1) ? k1 : k10)) begin
          errors++;
          $display("FAIL plain_vector i=%0d key=%h want %h", i, round_key, (i == 1) ? k1 : k10);
        end
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0 || key_valid !== 1'b0 || key_last !== 1'b0 || round_key !== ref_keys[10]) begin
      errors++;
      $display("FAIL plain_done busy=%b valid=%b last=%b key=%h want 0 0 0 %h",
               busy, key_valid, key_last, round_key, ref_keys[10]);
    end
  endtask

  task automatic test_backpressure_and_start();
    logic [127:0] key = rand_key();
    compute_ref(key);
    key_ready = 1'b1;
    launch(key);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== ref_keys[i] || key_last !== (i == 10)) begin
        errors++;
        $display("FAIL bp_seq i=%0d valid=%b idx=%0d key=%h want %h", i, key_valid, round_idx, round_key, ref_keys[i]);
      end
      if (i == 4) begin
        key_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if (key_valid !== 1'b1 || round_idx !== 4'd4 || round_key !== ref_keys[4] || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold s=%0d valid=%b idx=%0d key=%h want idx 4 key %h", s, key_valid, round_idx, round_key, ref_keys[4]);
          end
        end
        key_ready = 1'b1;
      end
      if (i == 5) begin
        start  = 1'b1;
        key_in = ~key;
      end
      tick();
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done busy=%b valid=%b want 0 0", busy, key_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] key = rand_key();
    compute_ref(key);
    key_ready = 1'b1;
    launch(key);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (round_idx !== 4'd6 || round_key !== ref_keys[6]) begin
      errors++;
      $display("FAIL rst_pre idx=%0d key=%h want 6 %h", round_idx, round_key, ref_keys[6]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || round_key !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid valid=%b busy=%b key=%h want 0 0 0", key_valid, busy, round_key);
    end
    key = rand_key();
    compute_ref(key);
    launch(key);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== ref_keys[i]) begin
        errors++;
        $display("FAIL rst_restart i=%0d valid=%b idx=%0d key=%h want %h", i, key_valid, round_idx, round_key, ref_keys[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka = rand_key();
    logic [127:0] kb = rand_key();
    compute_ref(ka);
    key_ready = 1'b1;
    launch(ka);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (key_last !== 1'b1 || round_key !== ref_keys[10]) begin
      errors++;
      $display("FAIL b2b_last last=%b key=%h want 1 %h", key_last, round_key, ref_keys[10]);
    end
    start  = 1'b1;
    key_in = kb;
    tick();
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop valid=%b busy=%b want 0 0", key_valid, busy);
    end
    compute_ref(kb);
    launch(kb);
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== ref_keys[i]) begin
        errors++;
        $display("FAIL b2b_seq i=%0d valid=%b idx=%0d key=%h want %h", i, key_valid, round_idx, round_key, ref_keys[i]);
      end
      tick();
    end
  endtask

  task automatic test_random_ready();
    for (int n = 0; n < 4; n++) begin
      logic [127:0] key = rand_key();
      int  e = 0;
      bit  done = 0;
      compute_ref(key);
      key_ready = 1'b0;
      launch(key);
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        checks++;
        if (key_valid !== 1'b1 || round_idx !== 4'(e) || round_key !== ref_keys[e] || key_last !== (e == 10)) begin
          errors++;
          $display("FAIL rand_seq n=%0d e=%0d valid=%b idx=%0d key=%h want %h", n, e, key_valid, round_idx, round_key, ref_keys[e]);
        end
        key_ready = 1'($urandom_range(0, 1));
        if (key_ready) begin
          if (e == 10) done = 1;
          else e++;
        end
        tick();
      end
      checks++;
      if (!done || busy !== 1'b0 || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_done n=%0d done=%0d busy=%b valid=%b want 1 0 0", n, done, busy, key_valid);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_plain_run(128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'ha0fafe1788542cb123a339392a6c7605,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_plain_run(128'h0,
                   128'h62636363626363636263636362636363,
                   128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    test_backpressure_and_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
